// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard detection, forwarding selection and halt sequencing for
// the 5-stage MIPS pipeline. Stall/flush/forward outputs are combinational;
// the RUN/DRAIN/HALT state, drain counter and stall counter are registered.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [31:0]      instrD,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic             JrD,
    input  logic             PCSrcD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic [4:0]       WriteRegW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [1:0]       ForwardAD,
    output logic [1:0]       ForwardBD,
    output logic             done,
    output logic [CNT_W-1:0] stall_cnt
);

    // Drain counter only needs to hold DRAIN_CYCLES-1; keep at least one bit.
    localparam int              DCW        = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCW-1:0]  DRAIN_LOAD = DCW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DCW-1:0]   r_drain_cnt;
    logic [DCW-1:0]   w_drain_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_haltD;
    logic w_lwstall;
    logic w_brstall;
    logic w_hazard;
    logic w_e_rs, w_e_rt, w_m_rs, w_m_rt;

    // A destination register matches a source only when it is not $zero.
    function automatic logic reg_match(input logic [4:0] wr, input logic [4:0] rd);
        return (wr != 5'd0) && (wr == rd);
    endfunction

    // MEM result is newer than WB, so it wins when both would match.
    function automatic logic [1:0] fwd_sel(
        input logic       rw_m,
        input logic [4:0] wr_m,
        input logic       rw_w,
        input logic [4:0] wr_w,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rw_m && reg_match(wr_m, src)) begin
            sel = 2'b10;
        end else if (rw_w && reg_match(wr_w, src)) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    assign w_haltD = (instrD == 32'hffff_ffff);

    assign w_e_rs = reg_match(WriteRegE, rsD);
    assign w_e_rt = reg_match(WriteRegE, rtD);
    assign w_m_rs = reg_match(WriteRegM, rsD);
    assign w_m_rt = reg_match(WriteRegM, rtD);

    // Load-use and branch-operand hazards; the halt word's rs/rt fields are ignored.
    always_comb begin
        w_lwstall = 1'b0;
        w_brstall = 1'b0;
        if (!w_haltD) begin
            w_lwstall = RegWriteE & MemtoRegE & (w_e_rs | w_e_rt);
            w_brstall = (BranchD & ((RegWriteE & (w_e_rs | w_e_rt)) |
                                    (MemtoRegM & (w_m_rs | w_m_rt)))) |
                        (JrD     & ((RegWriteE & w_e_rs) | (MemtoRegM & w_m_rs)));
        end
        w_hazard = w_lwstall | w_brstall | w_haltD;
    end

    assign ForwardAE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, rsE);
    assign ForwardBE = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, rtE);
    assign ForwardAD = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, rsD);
    assign ForwardBD = fwd_sel(RegWriteM, WriteRegM, RegWriteW, WriteRegW, rtD);

    // State register and drain counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_RUN;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
        end
    end

    // Next-state logic plus stall/flush/done outputs for each state.
    always_comb begin
        w_state_nxt = r_state;
        w_drain_nxt = r_drain_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushE      = 1'b0;
        FlushD      = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_RUN: begin
                StallF = w_hazard;
                StallD = w_hazard;
                FlushE = w_hazard;
                // A redirect during a stall is dropped; the branch resolves again next cycle.
                FlushD = (PCSrcD | JumpD) & ~w_hazard;
                if (w_haltD) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = DRAIN_LOAD;
                end
            end
            S_DRAIN: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                if (r_drain_cnt == '0) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_drain_nxt = r_drain_cnt - DCW'(1);
                end
            end
            S_HALT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                done   = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // Count RUN-state stall cycles, saturating at all ones.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table vectors, hand sequences for load-use, branch,
// halt drain, reset mid-drain and counter saturation, then random stimulus
// checked against a cycle-level model.
module tb_hazard_ctrl;

    localparam int DRAIN   = 4;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [31:0]   instrD;
    logic [4:0]    rsD, rtD, rsE, rtE, WriteRegE, WriteRegM, WriteRegW;
    logic          BranchD, JumpD, JrD, PCSrcD;
    logic          RegWriteE, MemtoRegE, RegWriteM, MemtoRegM, RegWriteW;
    logic          StallF, StallD, FlushD, FlushE, done;
    logic [1:0]    ForwardAE, ForwardBE, ForwardAD, ForwardBD;
    logic [CW-1:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    // model state: m_age = 0 while running, k = k-th cycle after halt detect
    int m_age = 0;
    int m_cnt = 0;

    typedef struct {
        logic [31:0] instrD;
        logic [4:0]  rsD, rtD;
        logic        BranchD, JumpD, JrD, PCSrcD;
        logic [4:0]  rsE, rtE, WriteRegE;
        logic        RegWriteE, MemtoRegE;
        logic [4:0]  WriteRegM;
        logic        RegWriteM, MemtoRegM;
        logic [4:0]  WriteRegW;
        logic        RegWriteW;
        logic        e_stall, e_flushD;
        logic [1:0]  e_fae, e_fbe, e_fad, e_fbd;
    } vec_t;

    vec_t tbl[$];

    hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .instrD(instrD), .rsD(rsD), .rtD(rtD),
        .BranchD(BranchD), .JumpD(JumpD), .JrD(JrD), .PCSrcD(PCSrcD),
        .rsE(rsE), .rtE(rtE), .WriteRegE(WriteRegE), .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE), .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .MemtoRegM(MemtoRegM), .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ForwardAD(ForwardAD),
        .ForwardBD(ForwardBD), .done(done), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        instrD = v.instrD; rsD = v.rsD; rtD = v.rtD;
        BranchD = v.BranchD; JumpD = v.JumpD; JrD = v.JrD; PCSrcD = v.PCSrcD;
        rsE = v.rsE; rtE = v.rtE; WriteRegE = v.WriteRegE;
        RegWriteE = v.RegWriteE; MemtoRegE = v.MemtoRegE;
        WriteRegM = v.WriteRegM; RegWriteM = v.RegWriteM; MemtoRegM = v.MemtoRegM;
        WriteRegW = v.WriteRegW; RegWriteW = v.RegWriteW;
    endtask

    function automatic vec_t zvec();
        vec_t v;
        v.instrD = 32'd0; v.rsD = 5'd0; v.rtD = 5'd0;
        v.BranchD = 1'b0; v.JumpD = 1'b0; v.JrD = 1'b0; v.PCSrcD = 1'b0;
        v.rsE = 5'd0; v.rtE = 5'd0; v.WriteRegE = 5'd0;
        v.RegWriteE = 1'b0; v.MemtoRegE = 1'b0;
        v.WriteRegM = 5'd0; v.RegWriteM = 1'b0; v.MemtoRegM = 1'b0;
        v.WriteRegW = 5'd0; v.RegWriteW = 1'b0;
        v.e_stall = 1'b0; v.e_flushD = 1'b0;
        v.e_fae = 2'd0; v.e_fbe = 2'd0; v.e_fad = 2'd0; v.e_fbd = 2'd0;
        return v;
    endfunction

    // ---------------- reference model ----------------
    function automatic bit m_halt();
        return instrD == 32'hFFFF_FFFF;
    endfunction

    // Which register reads in ID are still waiting on an older instruction.
    function automatic bit m_stall();
        bit lw, br, rs_read, rt_read, e_busy, m_busy;
        if (m_age != 0) return 1'b1;
        if (m_halt()) return 1'b1;
        e_busy  = RegWriteE && (WriteRegE != 0);
        m_busy  = MemtoRegM && (WriteRegM != 0);
        lw      = RegWriteE && MemtoRegE && (WriteRegE != 0) &&
                  (WriteRegE == rsD || WriteRegE == rtD);
        rs_read = BranchD || JrD;
        rt_read = BranchD;
        br = (rs_read && ((e_busy && WriteRegE == rsD) || (m_busy && WriteRegM == rsD))) ||
             (rt_read && ((e_busy && WriteRegE == rtD) || (m_busy && WriteRegM == rtD)));
        return lw || br;
    endfunction

    function automatic int m_fwd(input logic [4:0] src);
        if (RegWriteM && WriteRegM != 0 && WriteRegM == src) return 2;
        if (RegWriteW && WriteRegW != 0 && WriteRegW == src) return 1;
        return 0;
    endfunction

    task automatic check_model(input string tag);
        bit st, fd;
        st = m_stall();
        fd = (m_age == 0) && (PCSrcD || JumpD) && !st;
        chk({tag, "_StallF"}, int'(StallF), int'(st));
        chk({tag, "_StallD"}, int'(StallD), int'(st));
        chk({tag, "_FlushE"}, int'(FlushE), int'(st));
        chk({tag, "_FlushD"}, int'(FlushD), int'(fd));
        chk({tag, "_FwdAE"}, int'(ForwardAE), m_fwd(rsE));
        chk({tag, "_FwdBE"}, int'(ForwardBE), m_fwd(rtE));
        chk({tag, "_FwdAD"}, int'(ForwardAD), m_fwd(rsD));
        chk({tag, "_FwdBD"}, int'(ForwardBD), m_fwd(rtD));
        chk({tag, "_done"}, int'(done), int'(m_age > DRAIN));
        chk({tag, "_cnt"}, int'(stall_cnt), m_cnt);
    endtask

    // Advance one clock edge; leaves time at posedge+1 for driving inputs.
    task automatic step();
        bit st, run, h;
        st  = m_stall();
        run = (m_age == 0);
        h   = m_halt();
        @(posedge CLK);
        if (run && st && m_cnt < CNT_MAX) m_cnt++;
        if (m_age > 0) m_age++;
        else if (h) m_age = 1;
        #1;
    endtask

    // Mid-cycle reset pulse with idle inputs; outputs must clear at once.
    task automatic do_reset(input string tag);
        @(posedge CLK);
        #2;
        drive(zvec());
        RST_N = 1'b0;
        #1;
        m_age = 0;
        m_cnt = 0;
        chk({tag, "_rst_stall"}, int'({StallF, StallD, FlushE, FlushD}), 0);
        chk({tag, "_rst_fwd"}, int'({ForwardAE, ForwardBE, ForwardAD, ForwardBD}), 0);
        chk({tag, "_rst_done"}, int'(done), 0);
        chk({tag, "_rst_cnt"}, int'(stall_cnt), 0);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    // Halt word already on instrD and cycle N being sampled now.
    task automatic halt_body(input string tag, input int cnt_after);
        check_model({tag, "_N"});
        chk({tag, "_N_stall"}, int'(StallD), 1);
        step();
        for (int k = 1; k <= DRAIN + 3; k++) begin
            @(negedge CLK);
            check_model($sformatf("%s_N%0d", tag, k));
            chk($sformatf("%s_done_N%0d", tag, k), int'(done), (k > DRAIN) ? 1 : 0);
            chk($sformatf("%s_cnt_N%0d", tag, k), int'(stall_cnt), cnt_after);
            step();
        end
    endtask

    vec_t v;

    initial begin
        RST_N = 1'b0;
        drive(zvec());

        // ---------- table vectors ----------
        v = zvec(); tbl.push_back(v);
        v = zvec(); v.WriteRegE = 8; v.RegWriteE = 1; v.MemtoRegE = 1; v.rsD = 8;
        v.e_stall = 1; tbl.push_back(v);
        v = zvec(); v.WriteRegE = 8; v.RegWriteE = 1; v.MemtoRegE = 1; v.rtD = 8;
        v.e_stall = 1; tbl.push_back(v);
        v = zvec(); v.RegWriteE = 1; v.MemtoRegE = 1; tbl.push_back(v);
        v = zvec(); v.WriteRegM = 5; v.WriteRegW = 5; v.RegWriteM = 1; v.RegWriteW = 1;
        v.rsE = 5; v.e_fae = 2; tbl.push_back(v);
        v = zvec(); v.WriteRegM = 5; v.WriteRegW = 5; v.RegWriteW = 1;
        v.rsE = 5; v.e_fae = 1; tbl.push_back(v);
        v = zvec(); v.RegWriteM = 1; v.RegWriteW = 1; tbl.push_back(v);
        v = zvec(); v.BranchD = 1; v.rsD = 9; v.RegWriteE = 1; v.WriteRegE = 9;
        v.e_stall = 1; tbl.push_back(v);
        v = zvec(); v.BranchD = 1; v.rtD = 10; v.MemtoRegM = 1; v.RegWriteM = 1;
        v.WriteRegM = 10; v.e_stall = 1; v.e_fbd = 2; tbl.push_back(v);
        v = zvec(); v.JrD = 1; v.JumpD = 1; v.rtD = 9; v.RegWriteE = 1; v.WriteRegE = 9;
        v.e_flushD = 1; tbl.push_back(v);
        v = zvec(); v.BranchD = 1; v.PCSrcD = 1; v.e_flushD = 1; tbl.push_back(v);
        v = zvec(); v.JumpD = 1; v.RegWriteE = 1; v.MemtoRegE = 1; v.WriteRegE = 3;
        v.rtD = 3; v.e_stall = 1; tbl.push_back(v);
        v = zvec(); v.MemtoRegE = 1; v.WriteRegE = 8; v.rsD = 8; tbl.push_back(v);
        v = zvec(); v.RegWriteW = 1; v.WriteRegW = 7; v.rtE = 7; v.rtD = 7;
        v.e_fbe = 1; v.e_fbd = 1; tbl.push_back(v);

        do_reset("init");

        foreach (tbl[i]) begin
            drive(tbl[i]);
            @(negedge CLK);
            chk($sformatf("tbl%0d_StallF", i), int'(StallF), int'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_StallD", i), int'(StallD), int'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_FlushE", i), int'(FlushE), int'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_FlushD", i), int'(FlushD), int'(tbl[i].e_flushD));
            chk($sformatf("tbl%0d_FwdAE", i), int'(ForwardAE), int'(tbl[i].e_fae));
            chk($sformatf("tbl%0d_FwdBE", i), int'(ForwardBE), int'(tbl[i].e_fbe));
            chk($sformatf("tbl%0d_FwdAD", i), int'(ForwardAD), int'(tbl[i].e_fad));
            chk($sformatf("tbl%0d_FwdBD", i), int'(ForwardBD), int'(tbl[i].e_fbd));
            check_model($sformatf("tblm%0d", i));
            step();
        end

        // ---------- load-use: one stall, then MEM forward ----------
        do_reset("lu");
        v = zvec(); v.WriteRegE = 8; v.RegWriteE = 1; v.MemtoRegE = 1; v.rsD = 8;
        drive(v);
        @(negedge CLK);
        chk("lu_stall", int'({StallF, StallD, FlushE}), 7);
        step();
        v = zvec(); v.WriteRegM = 8; v.RegWriteM = 1; v.MemtoRegM = 1; v.rsE = 8;
        drive(v);
        @(negedge CLK);
        chk("lu_fwdAE", int'(ForwardAE), 2);
        chk("lu_nostall", int'(StallD), 0);
        chk("lu_cnt", int'(stall_cnt), 1);
        check_model("lu2");
        step();

        // ---------- branch hazard then resolve with forward ----------
        do_reset("br");
        v = zvec(); v.BranchD = 1; v.rsD = 9; v.RegWriteE = 1; v.WriteRegE = 9;
        drive(v);
        @(negedge CLK);
        chk("br_stall", int'(StallD), 1);
        chk("br_flushD_sup", int'(FlushD), 0);
        step();
        v = zvec(); v.BranchD = 1; v.rsD = 9; v.RegWriteM = 1; v.WriteRegM = 9; v.PCSrcD = 1;
        drive(v);
        @(negedge CLK);
        chk("br_fwdAD", int'(ForwardAD), 2);
        chk("br_flushD", int'(FlushD), 1);
        chk("br_stallD", int'(StallD), 0);
        check_model("br2");
        step();

        // ---------- halt drain ----------
        do_reset("halt");
        v = zvec(); v.instrD = 32'hFFFF_FFFF; v.rsD = 31; v.rtD = 31;
        v.RegWriteE = 1; v.MemtoRegE = 1; v.WriteRegE = 31;
        drive(v);
        @(negedge CLK);
        halt_body("halt", 1);

        // ---------- reset in the middle of the drain ----------
        do_reset("md");
        v = zvec(); v.instrD = 32'hFFFF_FFFF; v.rsD = 31; v.rtD = 31;
        drive(v);
        @(negedge CLK);
        check_model("md_N");
        step();
        step();
        #2;
        RST_N = 1'b0;
        #1;
        m_age = 0;
        m_cnt = 0;
        chk("md_rst_done", int'(done), 0);
        chk("md_rst_cnt", int'(stall_cnt), 0);
        chk("md_rst_run_stall", int'(StallF), 1);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        chk("md_held_done", int'(done), 0);
        RST_N = 1'b1;
        #1;
        halt_body("md_re", 1);

        // ---------- stall counter saturation ----------
        do_reset("sat");
        v = zvec(); v.WriteRegE = 4; v.RegWriteE = 1; v.MemtoRegE = 1; v.rsD = 4;
        drive(v);
        for (int i = 0; i < CNT_MAX + 5; i++) begin
            @(negedge CLK);
            check_model($sformatf("sat%0d", i));
            step();
        end
        @(negedge CLK);
        chk("sat_final", int'(stall_cnt), CNT_MAX);
        step();

        // ---------- random ----------
        do_reset("rnd");
        for (int i = 0; i < 400; i++) begin
            instrD    = (i == 360) ? 32'hFFFF_FFFF : $urandom;
            rsD       = 5'($urandom_range(0, 7));
            rtD       = 5'($urandom_range(0, 7));
            rsE       = 5'($urandom_range(0, 7));
            rtE       = 5'($urandom_range(0, 7));
            WriteRegE = 5'($urandom_range(0, 7));
            WriteRegM = 5'($urandom_range(0, 7));
            WriteRegW = 5'($urandom_range(0, 7));
            BranchD   = 1'($urandom_range(0, 1));
            JumpD     = 1'($urandom_range(0, 1));
            JrD       = 1'($urandom_range(0, 3) == 0);
            PCSrcD    = 1'($urandom_range(0, 1));
            RegWriteE = 1'($urandom_range(0, 1));
            MemtoRegE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1));
            MemtoRegM = 1'($urandom_range(0, 1));
            RegWriteW = 1'($urandom_range(0, 1));
            @(negedge CLK);
            check_model($sformatf("rnd%0d", i));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Observes register addresses and control bits from ID, EX, MEM and WB.
- Drives stall/flush enables for the IF/ID and ID/EX pipeline registers.
- Selects forwarding sources for the EX ALU operands and the ID branch comparator.
- Sequences the halt instruction (32'hffffffff) through a drain state machine before raising `done`.

## Interface
Parameters:
- DRAIN_CYCLES, 4, cycles spent draining older instructions after halt detect (>=1)
- CNT_W, 16, width of saturating stall-cycle counter

Ports:
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- instrD  in  32  instruction held in IF/ID register
- rsD, rtD  in  5  source register addresses in ID
- BranchD, JumpD, JrD  in  1  ID control: beq/bne, j/jal/jr, jr only
- PCSrcD  in  1  branch taken, resolved in ID
- rsE, rtE  in  5  source addresses in EX
- WriteRegE  in  5  destination register in EX
- RegWriteE, MemtoRegE  in  1  EX control
- WriteRegM  in  5  destination register in MEM
- RegWriteM, MemtoRegM  in  1  MEM control
- WriteRegW  in  5  destination register in WB
- RegWriteW  in  1  WB control
- StallF, StallD  out  1  hold PC / hold IF/ID register
- FlushD, FlushE  out  1  clear IF/ID / ID/EX register (bubble)
- ForwardAE, ForwardBE  out  2  EX operand source: 00 regfile, 01 WB, 10 MEM
- ForwardAD, ForwardBD  out  2  ID compare source: 00 regfile, 01 WB, 10 MEM
- done  out  1  CPU halted
- stall_cnt  out  CNT_W  RUN-state stall cycles, saturating

## Operation
- **State machine (registered):** RUN, DRAIN, HALT. Reset enters RUN, drain counter = 0, stall_cnt = 0.
- **haltD** = (instrD == 32'hffffffff).
  - While haltD=1, all D-side hazard checks are masked. The halt word decodes rsD=rtD=31, which must not cause false stalls.
- **Zero-register rule:** a compare against WriteReg* matches only when WriteReg* != 0.
- **lwstall** = RegWriteE & MemtoRegE & (WriteRegE==rsD | WriteRegE==rtD).
- **brstall** = (BranchD | JrD) & ((RegWriteE & WriteRegE matches rsD/rtD) | (MemtoRegM & WriteRegM matches rsD/rtD)).
  - JrD checks rsD only.
- **RUN outputs:**
  - StallF = StallD = FlushE = lwstall | brstall | haltD.
  - FlushD = (PCSrcD | JumpD) & ~StallD.
- **RUN -> DRAIN:** on the edge where haltD=1. Drain counter <= DRAIN_CYCLES-1.
- **DRAIN:**
  - StallF = StallD = FlushE = 1, FlushD = 0.
  - Counter decrements each edge.
  - When the counter is 0 at an edge -> HALT.
- **HALT:** StallF = StallD = FlushE = 1, FlushD = 0, done = 1. Exited only by reset.
- **ForwardAE:**
  - 10 if RegWriteM & WriteRegM matches rsE.
  - Else 01 if RegWriteW & WriteRegW matches rsE.
  - Else 00.
  - MEM has priority over WB.
  - ForwardBE is the same with rtE.
- **ForwardAD / ForwardBD:** same rule against rsD / rtD. Needed because the register file commits at the WB edge, after the ID read.
- **stall_cnt:** +1 on each edge in RUN with StallD=1. Holds at all-ones. Unchanged in DRAIN/HALT.

## Timing
- Stall, flush and forward outputs are combinational from inputs and current state: zero-cycle latency.
- The state machine, drain counter and stall_cnt update on CLK rising edge only.
- RST_N low forces RUN, counters 0, done=0 immediately (asynchronous), including mid-DRAIN or in HALT.
  - With all inputs 0 during reset: every output is 0.
- Halt detected in RUN cycle N:
  - Stalls assert in cycle N.
  - DRAIN covers cycles N+1 .. N+DRAIN_CYCLES.
  - done rises in cycle N+DRAIN_CYCLES+1 and stays high.
- Simultaneous lwstall and brstall: a single stall. stall_cnt +1 only.
- Simultaneous PCSrcD/JumpD and a stall: FlushD suppressed. The branch re-resolves next cycle with correct operands.
- lwstall lasts exactly 1 cycle per load. Once the load reaches MEM, forwarding (10) covers the dependency.
- Forwarding never selects register 0, even when RegWrite*=1.

## Test plan
- **Reset and idle.** Pulse RST_N low mid-cycle, all inputs 0 -> all outputs 0, done=0, stall_cnt=0 immediately.
- **Load-use.** EX: lw with WriteRegE=8, MemtoRegE=1, RegWriteE=1; ID: rsD=8. Expect StallF=StallD=FlushE=1 for one cycle. Next cycle (load in M): ForwardAE=10 when rsE=8, stall_cnt=1.
- **Forward priority and $zero.** WriteRegM=WriteRegW=5 with both RegWrite=1, rsE=5 -> ForwardAE=10. Drop RegWriteM -> 01. WriteRegM=WriteRegW=0, rsE=0 -> 00.
- **Branch hazard.** beq in ID with rsD=9, RegWriteE=1, WriteRegE=9 -> stall 1 cycle. Next cycle ForwardAD=10, PCSrcD=1 -> FlushD=1, StallD=0.
- **Halt drain.** instrD=32'hffffffff at cycle N, DRAIN_CYCLES=4:
  - Stalls in N; done=0 through N+4.
  - done=1 at N+5 and stays high.
  - No stall_cnt increments after N.
- **Reset mid-drain.** Assert RST_N low at N+2 of the halt sequence -> state RUN, done=0. After release with halt word still present, the full sequence restarts.
